// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry,
// common to uart_rx and the transmitter that will sit alongside it.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS     = 8;
  localparam int DEFAULT_SAMPLING_RATE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with one extra history flop, giving a clean level plus
// single-cycle rising and falling edge strobes in the clk domain.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= RESET_VAL;
      s2   <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1   <= d;
      s2   <= s1;
      s2_q <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s2_q;
  assign fall = ~s2 & s2_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: finds the start edge, checks mid start bit, samples
// each data bit and the stop bit at their centres, and strobes valid or frame_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = DEFAULT_DATA_BITS,
  parameter int SAMPLING_RATE = DEFAULT_SAMPLING_RATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(SAMPLING_RATE);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLING_RATE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLING_RATE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic rx_s, rx_rise, rx_fall;
  logic baud_s, tick, baud_fall;
  logic unused;

  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;

  // The line idles high, so its synchronizer resets to 1 to avoid a false start.
  sync_edge #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s),
    .rise(rx_rise),
    .fall(rx_fall)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_baud_sync (
    .clk (clk),
    .rst (rst),
    .d   (baud),
    .q   (baud_s),
    .rise(tick),
    .fall(baud_fall)
  );

  assign unused = rx_rise ^ baud_s ^ baud_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        // Only a real high-to-low transition starts a frame; a stuck-low line never does.
        IDLE: begin
          if (rx_fall) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (cnt == CNT_HALF) begin
              cnt <= '0;
              if (!rx_s) begin
                state <= DATA;
                idx   <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        // Samples land one full bit after the start-bit centre, i.e. mid data bit.
        DATA: begin
          if (tick) begin
            if (cnt == CNT_LAST) begin
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              cnt   <= '0;
              if (idx == IDX_LAST) begin
                state <= STOP;
                idx   <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (cnt == CNT_LAST) begin
              data      <= shreg;
              valid     <= rx_s;
              frame_err <= ~rx_s;
              busy      <= 1'b0;
              cnt       <= '0;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: baud toggles every 4 clk (tick every 8 clk), frames
// are driven bit by bit with # delays and strobes are logged on the falling clk edge.
module tb_uart_rx;

  localparam int TICK_NS  = 80;
  localparam int BIT_NS   = 16 * TICK_NS;
  localparam int FRAME_NS = 10 * BIT_NS;
  // 152 ticks, plus the fixed detect/strobe/sample offset for a start bit
  // driven 20 ns after a baud rising edge.
  localparam int LAT_NS     = 152 * TICK_NS + 10;
  localparam int LAT_TOL_NS = 30;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       baud = 1'b0;
  logic       rx   = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int  compareCount  = 0;
  int  mismatchCount = 0;
  int  validCount    = 0;
  int  errCount      = 0;
  time strobeTime    = 0;

  uart_rx dut (
    .clk      (clk),
    .rst      (rst),
    .baud     (baud),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial forever #5 clk = ~clk;
  initial forever #40 baud = ~baud;

  always @(negedge clk) begin
    if (valid) begin
      validCount = validCount + 1;
      strobeTime = $time;
    end
    if (frame_err) begin
      errCount   = errCount + 1;
      strobeTime = $time;
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected,
                             input int tol = 0);
    compareCount++;
    if (actual > expected + tol || actual < expected - tol) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) tol %0d",
               tag, actual, actual, expected, expected, tol);
    end
  endtask

  task automatic alignToBaud();
    @(posedge baud);
    #20;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #BIT_NS;
    end
    rx = stopBit;
    #BIT_NS;
  endtask

  initial begin
    int  v0, e0;
    time t0, t1;

    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reset_data", data, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single frame
    v0 = validCount; e0 = errCount;
    alignToBaud();
    t0 = $time;
    applyStimulus(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("single_valid", validCount - v0, 1);
    checkOutput("single_err", errCount - e0, 0);
    checkOutput("single_data", data, 8'h55);
    checkOutput("single_busy", busy, 0);
    checkOutput("single_lat", int'(strobeTime - t0), LAT_NS, LAT_TOL_NS);

    // Back-to-back frames, second start bit right after a full stop bit
    v0 = validCount; e0 = errCount;
    alignToBaud();
    t0 = $time;
    applyStimulus(8'hA3, 1'b1);
    checkOutput("b2b_data0", data, 8'hA3);
    checkOutput("b2b_lat0", int'(strobeTime - t0), LAT_NS, LAT_TOL_NS);
    t1 = strobeTime;
    applyStimulus(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("b2b_data1", data, 8'h00);
    checkOutput("b2b_valid", validCount - v0, 2);
    checkOutput("b2b_err", errCount - e0, 0);
    checkOutput("b2b_lat1", int'(strobeTime - (t0 + FRAME_NS)), LAT_NS, LAT_TOL_NS);
    checkOutput("b2b_gap", int'(strobeTime - t1), FRAME_NS);

    // Glitch: 3 ticks low, rejected at the mid-start check (8th tick)
    v0 = validCount; e0 = errCount;
    alignToBaud();
    t0 = $time;
    rx = 1'b0;
    #(3 * TICK_NS);
    rx = 1'b1;
    #(600 - 3 * TICK_NS);
    checkOutput("glitch_busy_hi", busy, 1);
    #100;
    checkOutput("glitch_busy_lo", busy, 0);
    #(2 * BIT_NS);
    checkOutput("glitch_valid", validCount - v0, 0);
    checkOutput("glitch_err", errCount - e0, 0);

    // Framing error, then a long low line, then recovery
    v0 = validCount; e0 = errCount;
    alignToBaud();
    t0 = $time;
    applyStimulus(8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("fe_err", errCount - e0, 1);
    checkOutput("fe_valid", validCount - v0, 0);
    checkOutput("fe_data", data, 8'hFF);
    checkOutput("fe_lat", int'(strobeTime - t0), LAT_NS, LAT_TOL_NS);
    #(2 * FRAME_NS);
    checkOutput("fe_hold_busy", busy, 0);
    checkOutput("fe_hold_valid", validCount - v0, 0);
    checkOutput("fe_hold_err", errCount - e0, 1);
    rx = 1'b1;
    #BIT_NS;
    v0 = validCount;
    alignToBaud();
    t0 = $time;
    applyStimulus(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("fe_rec_valid", validCount - v0, 1);
    checkOutput("fe_rec_data", data, 8'h3C);
    checkOutput("fe_rec_lat", int'(strobeTime - t0), LAT_NS, LAT_TOL_NS);

    // Reset for one clk during data bit 4 of 0xC9
    v0 = validCount; e0 = errCount;
    alignToBaud();
    t0 = $time;
    fork
      applyStimulus(8'hC9, 1'b1);
      begin
        #(5 * BIT_NS + 600);
        @(negedge clk);
        checkOutput("rst_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy_after", busy, 0);
      end
    join
    checkOutput("rst_valid", validCount - v0, 0);
    checkOutput("rst_err", errCount - e0, 0);
    checkOutput("rst_data", data, 0);
    // The line was mid-frame at reset release, so the receiver may lock onto a
    // later low data bit; give that a full idle stretch before the next frame.
    #(2 * FRAME_NS);
    v0 = validCount;
    alignToBaud();
    t0 = $time;
    applyStimulus(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("rst_rec_valid", validCount - v0, 1);
    checkOutput("rst_rec_data", data, 8'h3C);
    checkOutput("rst_rec_lat", int'(strobeTime - t0), LAT_NS, LAT_TOL_NS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
